// File: rtl/byte_striping_tx_if.sv
// Bundle of the byte-striping transmitter's streaming input and its
// lane-aligned word output. The master side feeds bytes and watches the
// word; the slave side is the striper itself.
interface byte_striping_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  flush_in;
  logic [DATA_WIDTH-1:0] data_out0;
  logic [DATA_WIDTH-1:0] data_out1;
  logic [DATA_WIDTH-1:0] data_out2;
  logic [DATA_WIDTH-1:0] data_out3;
  logic                  valid_out;
  logic [3:0]            lane_mask;
  logic [1:0]            lane_ptr;
  logic [3:0]            parity_out;

  modport master (
    output valid_in, data_in, flush_in,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out, lane_mask, lane_ptr, parity_out
  );

  modport slave (
    input  valid_in, data_in, flush_in,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out, lane_mask, lane_ptr, parity_out
  );

endinterface

// File: rtl/byte_striping_tx.sv
// Transmit-side 4-lane byte striper. Serial bytes are spread round-robin
// over lanes 0..3 and presented as one lane-aligned word with a single
// valid strobe. A flush closes a partial word, padding unfilled lanes.
// Optional per-lane even parity is enabled by BYTE_STRIPING_TX_PARITY_EN;
// without it parity_out is tied low.
module byte_striping_tx #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = 8'hBC
) (
  input logic                clk,
  input logic                reset,
  byte_striping_tx_if.slave  bus
);

  // One-hot FSM: the set bit is the next lane to be filled.
  localparam logic [3:0] LANE0 = 4'b0001;
  localparam logic [3:0] LANE1 = 4'b0010;
  localparam logic [3:0] LANE2 = 4'b0100;
  localparam logic [3:0] LANE3 = 4'b1000;

  logic [3:0]            state_q, state_d;
  logic [1:0]            ptr;
  logic [2:0]            fill;
  logic                  emit;
  logic [DATA_WIDTH-1:0] stage_q [4];
  logic [DATA_WIDTH-1:0] word_d  [4];
  logic [3:0]            mask_d;
  logic [DATA_WIDTH-1:0] data_q  [4];
  logic [3:0]            mask_q;
  logic                  valid_q;

  function automatic logic [3:0] oneHot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Binary lane pointer decoded from the one-hot state; an illegal state
  // decodes as lane 0 so the next-state logic pulls it back to LANE0.
  always_comb begin
    ptr = 2'd0;
    case (state_q)
      LANE0:   ptr = 2'd0;
      LANE1:   ptr = 2'd1;
      LANE2:   ptr = 2'd2;
      LANE3:   ptr = 2'd3;
      default: ptr = 2'd0;
    endcase
  end

  // Build the candidate word: lanes below the pointer come from staging,
  // the pointer lane takes the incoming byte if one arrives, everything
  // above is padding. A word is emitted when lane 3 is filled, or on a
  // flush that has at least one real byte to carry.
  always_comb begin
    fill    = {1'b0, ptr} + {2'b00, bus.valid_in};
    emit    = (bus.valid_in && (ptr == 2'd3)) || (bus.flush_in && (fill != 3'd0));
    mask_d  = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < {1'b0, ptr}) begin
        word_d[j] = stage_q[j];
      end else if ((3'(j) == {1'b0, ptr}) && bus.valid_in) begin
        word_d[j] = bus.data_in;
      end else begin
        word_d[j] = PAD_BYTE;
      end
      mask_d[j] = (3'(j) < fill);
    end
    if (emit) begin
      state_d = LANE0;
    end else if (bus.valid_in) begin
      state_d = oneHot(ptr + 2'd1);
    end else begin
      state_d = oneHot(ptr);
    end
  end

  // State register and byte staging. Staging is never cleared on emit;
  // stale entries are always masked and padded out of later words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE0;
      stage_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      if (bus.valid_in) begin
        stage_q[ptr] <= bus.data_in;
      end
    end
  end

  // Output word register: loads only on emit, so the last word is held
  // while the strobe is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '{default: '0};
      mask_q  <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= emit;
      if (emit) begin
        data_q <= word_d;
        mask_q <= mask_d;
      end
    end
  end

`ifdef BYTE_STRIPING_TX_PARITY_EN
  logic [3:0] parity_q;

  // Per-lane parity captured alongside the word, pad lanes included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 4'b0000;
    end else if (emit) begin
      for (int j = 0; j < 4; j++) begin
        parity_q[j] <= ^word_d[j];
      end
    end
  end

  assign bus.parity_out = parity_q;
`else
  assign bus.parity_out = 4'b0000;
`endif

  assign bus.data_out0 = data_q[0];
  assign bus.data_out1 = data_q[1];
  assign bus.data_out2 = data_q[2];
  assign bus.data_out3 = data_q[3];
  assign bus.valid_out = valid_q;
  assign bus.lane_mask = mask_q;
  assign bus.lane_ptr  = ptr;

endmodule

// File: tb/tb_byte_striping_tx.sv
// Scoreboard bench for byte_striping_tx: directed byte sequences push
// hand-computed words into a queue; a negedge monitor pops and compares
// each strobed word, including the cycle it was due on.
module tb_byte_striping_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [7:0]  d0, d1, d2, d3;
    logic [3:0]  mask;
    logic [3:0]  par;
    logic [31:0] due;
  } word_t;

  word_t expQ[$];

  byte_striping_tx_if #(.DATA_WIDTH(8)) bus ();

  byte_striping_tx #(.DATA_WIDTH(8), .PAD_BYTE(8'hBC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp expected strobes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of input just after the active edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic f);
    @(posedge clk);
    #1;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.flush_in = f;
  endtask

  // Queue the word expected on the edge that samples the current inputs.
  task automatic expectWord(input logic [7:0] a, b, c, d, input logic [3:0] m, input logic [3:0] p);
    word_t w;
    w.d0 = a; w.d1 = b; w.d2 = c; w.d3 = d;
    w.mask = m;
`ifdef BYTE_STRIPING_TX_PARITY_EN
    w.par = p;
`else
    w.par = 4'b0000;
`endif
    w.due = cyc + 1;
    expQ.push_back(w);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.valid_out) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        word_t w;
        w = expQ.pop_front();
        checkOutput("strobe_cycle", cyc, w.due);
        checkOutput("data_out0", {24'd0, bus.data_out0}, {24'd0, w.d0});
        checkOutput("data_out1", {24'd0, bus.data_out1}, {24'd0, w.d1});
        checkOutput("data_out2", {24'd0, bus.data_out2}, {24'd0, w.d2});
        checkOutput("data_out3", {24'd0, bus.data_out3}, {24'd0, w.d3});
        checkOutput("lane_mask", {28'd0, bus.lane_mask}, {28'd0, w.mask});
        checkOutput("parity_out", {28'd0, bus.parity_out}, {28'd0, w.par});
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_d0"}, {24'd0, bus.data_out0}, 32'd0);
    checkOutput({tag, "_d1"}, {24'd0, bus.data_out1}, 32'd0);
    checkOutput({tag, "_d2"}, {24'd0, bus.data_out2}, 32'd0);
    checkOutput({tag, "_d3"}, {24'd0, bus.data_out3}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    checkOutput({tag, "_mask"}, {28'd0, bus.lane_mask}, 32'd0);
    checkOutput({tag, "_ptr"}, {30'd0, bus.lane_ptr}, 32'd0);
    checkOutput({tag, "_parity"}, {28'd0, bus.parity_out}, 32'd0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    bus.flush_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    // Single full word.
    applyStimulus(1, 8'h11, 0);
    applyStimulus(1, 8'h22, 0);
    applyStimulus(1, 8'h33, 0);
    applyStimulus(1, 8'h44, 0);
    expectWord(8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 4'b0000);
    applyStimulus(0, 8'h00, 0);

    // Back-to-back words, strobes 4 cycles apart.
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h02, 0);
    applyStimulus(1, 8'h03, 0);
    applyStimulus(1, 8'h04, 0);
    expectWord(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, 4'b1011);
    applyStimulus(1, 8'h05, 0);
    applyStimulus(1, 8'h06, 0);
    applyStimulus(1, 8'h07, 0);
    applyStimulus(1, 8'h08, 0);
    expectWord(8'h05, 8'h06, 8'h07, 8'h08, 4'b1111, 4'b1100);

    // Gaps in valid_in only delay the word.
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h02, 0);
    applyStimulus(0, 8'hEE, 0);
    applyStimulus(0, 8'hEE, 0);
    applyStimulus(1, 8'h03, 0);
    applyStimulus(1, 8'h04, 0);
    expectWord(8'h01, 8'h02, 8'h03, 8'h04, 4'b1111, 4'b1011);

    // Flush alone in LANE2.
    applyStimulus(1, 8'hA1, 0);
    applyStimulus(1, 8'hA2, 0);
    applyStimulus(0, 8'h00, 1);
    expectWord(8'hA1, 8'hA2, 8'hBC, 8'hBC, 4'b0011, 4'b1111);
    applyStimulus(0, 8'h00, 0);
    checkOutput("ptr_after_flush", {30'd0, bus.lane_ptr}, 32'd0);
    applyStimulus(1, 8'hC1, 0);
    applyStimulus(1, 8'hC2, 0);
    applyStimulus(1, 8'hC3, 0);
    applyStimulus(1, 8'hC4, 0);
    expectWord(8'hC1, 8'hC2, 8'hC3, 8'hC4, 4'b1111, 4'b1011);

    // Byte plus flush in LANE2.
    applyStimulus(1, 8'h53, 0);
    applyStimulus(1, 8'h54, 0);
    checkOutput("ptr_mid_word", {30'd0, bus.lane_ptr}, 32'd1);
    applyStimulus(1, 8'h55, 1);
    expectWord(8'h53, 8'h54, 8'h55, 8'hBC, 4'b0111, 4'b1010);
    applyStimulus(0, 8'h00, 0);

    // Flush alone in LANE0 must not strobe.
    applyStimulus(0, 8'h00, 1);
    applyStimulus(0, 8'h00, 0);
    applyStimulus(0, 8'h00, 0);
    checkOutput("ptr_after_noop", {30'd0, bus.lane_ptr}, 32'd0);

    // Byte plus flush filling lane 3 is a normal full word.
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h03, 0);
    applyStimulus(1, 8'h07, 0);
    applyStimulus(1, 8'hFF, 1);
    expectWord(8'h01, 8'h03, 8'h07, 8'hFF, 4'b1111, 4'b0101);
    applyStimulus(0, 8'h00, 0);

    // Flush alone in LANE3.
    applyStimulus(1, 8'h01, 0);
    applyStimulus(1, 8'h03, 0);
    applyStimulus(1, 8'h07, 0);
    applyStimulus(0, 8'h00, 1);
    expectWord(8'h01, 8'h03, 8'h07, 8'hBC, 4'b0111, 4'b1101);
    applyStimulus(0, 8'h00, 0);

    // Asynchronous reset mid-word, with a 4th byte pending.
    applyStimulus(1, 8'h66, 0);
    applyStimulus(1, 8'h77, 0);
    applyStimulus(1, 8'h78, 0);
    applyStimulus(1, 8'h79, 0);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    bus.valid_in = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(1, 8'h88, 1);
    expectWord(8'h88, 8'hBC, 8'hBC, 8'hBC, 4'b0001, 4'b1110);

    repeat (5) applyStimulus(0, 8'h00, 0);
    @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
